// File: rtl/async_fifo_pkg.sv
// Shared async FIFO definitions: pointer type, depth and Gray/binary conversion.
package async_fifo_pkg;

  localparam int unsigned ADDR_BITS = 4;
  localparam int unsigned DEPTH     = 2 ** ADDR_BITS;

  typedef logic [ADDR_BITS:0] ptr_t;

  // Conversions operate on a wide word; callers zero-extend their pointer into it and
  // truncate the result, which keeps one function valid for any pointer width.
  localparam int unsigned GRAY_MAX_W = 32;
  typedef logic [GRAY_MAX_W-1:0] gray_word_t;

  function automatic gray_word_t bin2gray(input gray_word_t bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic gray_word_t gray2bin(input gray_word_t gray);
    gray_word_t bin;
    bin[GRAY_MAX_W-1] = gray[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/async_fifo_wptr_ctrl_if.sv
// Write-side bus of the async FIFO: client request, RAM port, status and pointer exchange.
interface async_fifo_wptr_ctrl_if
  import async_fifo_pkg::*;
#(
  parameter int unsigned ADDRSIZE = ADDR_BITS
);

  logic                winc;
  logic                wovf_clr;
  logic [ADDRSIZE:0]   rptr;
  logic                wen;
  logic [ADDRSIZE-1:0] waddr;
  logic [ADDRSIZE:0]   wptr;
  logic                full;
  logic                almost_full;
  logic [ADDRSIZE:0]   wlevel;
  logic                wovf;

  // Client / environment side.
  modport master (
    output winc, wovf_clr, rptr,
    input  wen, waddr, wptr, full, almost_full, wlevel, wovf
  );

  // Controller side.
  modport slave (
    input  winc, wovf_clr, rptr,
    output wen, waddr, wptr, full, almost_full, wlevel, wovf
  );

endinterface

// File: rtl/sync_nff.sv
// Plain N-flop synchroniser chain with asynchronous active-low reset.
module sync_nff #(
  parameter int unsigned WIDTH  = 1,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [STAGES-1:0][WIDTH-1:0] stage_q;

  // Shift the asynchronous input through the chain; stage 0 is the metastability catcher.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= '0;
    end else begin
      stage_q <= {stage_q[STAGES-2:0], d};
    end
  end

  assign q = stage_q[STAGES-1];

endmodule

// File: rtl/async_fifo_wptr_ctrl.sv
// Write-domain pointer/flag controller: Gray write pointer, full/almost-full, level, overflow.
module async_fifo_wptr_ctrl
  import async_fifo_pkg::*;
#(
  parameter int unsigned ADDRSIZE     = ADDR_BITS,
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned AFULL_THRESH = 12
) (
  input logic                   wclk,
  input logic                   wrst_n,
  async_fifo_wptr_ctrl_if.slave bus
);

  typedef logic [ADDRSIZE:0] wptr_t;

  localparam wptr_t AfullThresh = wptr_t'(AFULL_THRESH);

  wptr_t wbin_q, wbin_d;
  wptr_t wptr_q, wptr_d;
  wptr_t level_q, level_d;
  wptr_t rptr_s, rbin_s, rptr_full;
  logic  full_q, full_d;
  logic  afull_q, afull_d;
  logic  wovf_q, wovf_d;
  logic  wen;

  sync_nff #(
    .WIDTH  (ADDRSIZE + 1),
    .STAGES (SYNC_STAGES)
  ) u_rptr_sync (
    .clk   (wclk),
    .rst_n (wrst_n),
    .d     (bus.rptr),
    .q     (rptr_s)
  );

  // Next-state for pointers and flags; flags use the post-write pointer so they are never optimistic.
  always_comb begin
    wen       = bus.winc & ~full_q;
    wbin_d    = wbin_q + wptr_t'(wen);
    wptr_d    = wptr_t'(bin2gray(gray_word_t'(wbin_d)));
    rbin_s    = wptr_t'(gray2bin(gray_word_t'(rptr_s)));
    // Full when write pointer is one lap ahead: top two Gray bits inverted, rest equal.
    rptr_full = {~rptr_s[ADDRSIZE:ADDRSIZE-1], rptr_s[ADDRSIZE-2:0]};
    full_d    = (wptr_d == rptr_full);
    level_d   = wbin_d - rbin_s;
    afull_d   = (level_d >= AfullThresh);
    // A new overflow takes priority over a simultaneous clear.
    wovf_d    = (bus.winc & full_q) | (wovf_q & ~bus.wovf_clr);
  end

  // State registers; reset clears everything without waiting for the read domain.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin_q  <= '0;
      wptr_q  <= '0;
      level_q <= '0;
      full_q  <= 1'b0;
      afull_q <= 1'b0;
      wovf_q  <= 1'b0;
    end else begin
      wbin_q  <= wbin_d;
      wptr_q  <= wptr_d;
      level_q <= level_d;
      full_q  <= full_d;
      afull_q <= afull_d;
      wovf_q  <= wovf_d;
    end
  end

  assign bus.wen         = wen;
  assign bus.waddr       = wbin_q[ADDRSIZE-1:0];
  assign bus.wptr        = wptr_q;
  assign bus.full        = full_q;
  assign bus.almost_full = afull_q;
  assign bus.wlevel      = level_q;
  assign bus.wovf        = wovf_q;

endmodule

// File: tb/tb_async_fifo_wptr_ctrl.sv
// Scoreboard bench for async_fifo_wptr_ctrl (ADDRSIZE=4, SYNC_STAGES=2, AFULL_THRESH=12).
module tb_async_fifo_wptr_ctrl;

  logic wclk   = 1'b0;
  logic wrst_n = 1'b0;

  async_fifo_wptr_ctrl_if #(.ADDRSIZE(4)) bus ();

  async_fifo_wptr_ctrl #(
    .ADDRSIZE     (4),
    .SYNC_STAGES  (2),
    .AFULL_THRESH (12)
  ) dut (
    .wclk   (wclk),
    .wrst_n (wrst_n),
    .bus    (bus)
  );

  always #5 wclk = ~wclk;

  typedef struct {
    string      name;
    logic [4:0] level;
    logic [4:0] wptr;
    logic [3:0] waddr;
    logic       full;
    logic       afull;
    logic       wovf;
    logic       wen;
    int         occ;
  } exp_t;

  exp_t sb_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Reference model: counts in binary, read pointer delayed two cycles.
  logic [4:0] m_wbin;
  logic [4:0] m_level;
  logic [4:0] m_sync0, m_sync1;
  logic       m_full, m_afull, m_wovf;
  int         m_wcnt;
  int         rd;
  logic       cur_winc, cur_clr;

  function automatic logic [4:0] g(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic hand(input string name, input logic [4:0] level, input logic [4:0] wptr,
                      input logic [3:0] waddr, input logic full, input logic afull,
                      input logic wovf, input logic wen);
    exp_t e;
    e.name = name; e.level = level; e.wptr = wptr; e.waddr = waddr;
    e.full = full; e.afull = afull; e.wovf = wovf; e.wen = wen; e.occ = -1;
    sb_q.push_back(e);
  endtask

  task automatic drive(input logic w, input logic c);
    exp_t e;
    cur_winc     = w;
    cur_clr      = c;
    bus.winc     = w;
    bus.wovf_clr = c;
    bus.rptr     = g(rd[4:0]);
    e.name  = "model";
    e.level = m_level;
    e.wptr  = g(m_wbin);
    e.waddr = m_wbin[3:0];
    e.full  = m_full;
    e.afull = m_afull;
    e.wovf  = m_wovf;
    e.wen   = w & ~m_full;
    e.occ   = m_wcnt - rd;
    sb_q.push_back(e);
  endtask

  task automatic tick();
    logic       mw;
    logic [4:0] nx, diff;
    @(posedge wclk);
    mw      = cur_winc & ~m_full;
    nx      = m_wbin + {4'd0, mw};
    diff    = nx - m_sync1;
    m_wovf  = (cur_winc & m_full) | (m_wovf & ~cur_clr);
    m_full  = (diff == 5'd16);
    m_afull = (diff >= 5'd12);
    m_level = diff;
    m_sync1 = m_sync0;
    m_sync0 = rd[4:0];
    m_wbin  = nx;
    m_wcnt  = m_wcnt + int'(mw);
    #1;
  endtask

  task automatic step(input logic w, input logic c);
    drive(w, c);
    tick();
  endtask

  // Asserted one unit after a rising edge, i.e. mid-cycle; checked at the following falling edge.
  task automatic do_reset();
    wrst_n       = 1'b0;
    bus.winc     = 1'b0;
    bus.wovf_clr = 1'b0;
    rd           = 0;
    bus.rptr     = 5'd0;
    m_wbin = '0; m_level = '0; m_sync0 = '0; m_sync1 = '0;
    m_full = 1'b0; m_afull = 1'b0; m_wovf = 1'b0; m_wcnt = 0;
    hand("reset_state", 5'd0, 5'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge wclk);
    #1;
    wrst_n = 1'b1;
  endtask

  // Monitor: pops every pending expectation at the falling edge and checks invariants.
  exp_t       mon_e;
  logic [4:0] prev_wptr;
  logic       prev_valid = 1'b0;

  always @(negedge wclk) begin
    while (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      vectors++;
      if (bus.wlevel !== mon_e.level || bus.wptr !== mon_e.wptr || bus.waddr !== mon_e.waddr ||
          bus.full !== mon_e.full || bus.almost_full !== mon_e.afull ||
          bus.wovf !== mon_e.wovf || bus.wen !== mon_e.wen) begin
        miscompares++;
        $display("FAIL %s @%0t: got lvl=%0d wptr=%b waddr=%0d full=%b af=%b ovf=%b wen=%b, want lvl=%0d wptr=%b waddr=%0d full=%b af=%b ovf=%b wen=%b",
                 mon_e.name, $time, bus.wlevel, bus.wptr, bus.waddr, bus.full, bus.almost_full,
                 bus.wovf, bus.wen, mon_e.level, mon_e.wptr, mon_e.waddr, mon_e.full,
                 mon_e.afull, mon_e.wovf, mon_e.wen);
      end
      if (mon_e.occ >= 0) begin
        vectors++;
        if (int'(bus.wlevel) < mon_e.occ) begin
          miscompares++;
          $display("FAIL level_pessimism @%0t: wlevel=%0d below true occupancy %0d",
                   $time, bus.wlevel, mon_e.occ);
        end
      end
    end
    if (wrst_n) begin
      vectors++;
      if (bus.wlevel > 5'd16) begin
        miscompares++;
        $display("FAIL level_bound @%0t: wlevel=%0d exceeds 16", $time, bus.wlevel);
      end
      vectors++;
      if (bus.wen && bus.full) begin
        miscompares++;
        $display("FAIL write_while_full @%0t: wen=%b full=%b, want wen=0", $time, bus.wen, bus.full);
      end
      if (prev_valid) begin
        vectors++;
        if ($countones(bus.wptr ^ prev_wptr) > 1) begin
          miscompares++;
          $display("FAIL gray_step @%0t: wptr %b -> %b, want at most one bit change",
                   $time, prev_wptr, bus.wptr);
        end
      end
      prev_wptr  = bus.wptr;
      prev_valid = 1'b1;
    end else begin
      prev_valid = 1'b0;
    end
  end

  initial begin
    bus.winc     = 1'b0;
    bus.wovf_clr = 1'b0;
    bus.rptr     = 5'd0;
    cur_winc     = 1'b0;
    cur_clr      = 1'b0;
    rd           = 0;
    @(posedge wclk);
    #1;

    // Fill to full, then overflow handling.
    do_reset();
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0);
    drive(1'b0, 1'b0);
    hand("full_after_16", 5'd16, 5'b11000, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b0);
    hand("ovf_dropped", 5'd16, 5'b11000, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    step(1'b1, 1'b0);
    drive(1'b0, 1'b0);
    hand("ovf_set", 5'd16, 5'b11000, 4'd0, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    step(1'b0, 1'b1);
    drive(1'b0, 1'b0);
    hand("ovf_cleared", 5'd16, 5'b11000, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    step(1'b1, 1'b1);
    drive(1'b0, 1'b0);
    hand("ovf_set_wins", 5'd16, 5'b11000, 4'd0, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();

    // Almost-full threshold and read-pointer propagation latency.
    do_reset();
    for (int i = 0; i < 11; i++) step(1'b1, 1'b0);
    drive(1'b0, 1'b0);
    hand("level_11", 5'd11, 5'b01110, 4'd11, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    step(1'b1, 1'b0);
    rd = 1;
    drive(1'b0, 1'b0);
    hand("afull_12", 5'd12, 5'b01010, 4'd12, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b0);
    hand("rd_edge1", 5'd12, 5'b01010, 4'd12, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b0);
    hand("rd_edge2", 5'd12, 5'b01010, 4'd12, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b0);
    hand("rd_edge3", 5'd11, 5'b01010, 4'd12, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();

    // Wrap-around with the reader trailing one step per write.
    do_reset();
    for (int i = 0; i < 40; i++) begin
      rd = (m_wcnt > 0) ? m_wcnt - 1 : 0;
      step(1'b1, 1'b0);
    end
    drive(1'b0, 1'b0);
    hand("wrap_steady", 5'd4, 5'b01100, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();

    // Asynchronous reset in the middle of operation.
    do_reset();
    for (int i = 0; i < 9; i++) step(1'b1, 1'b0);
    drive(1'b0, 1'b0);
    hand("level_9", 5'd9, 5'b01101, 4'd9, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    do_reset();
    drive(1'b1, 1'b0);
    hand("first_write_addr0", 5'd0, 5'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    drive(1'b0, 1'b0);
    hand("after_first_write", 5'd1, 5'b00001, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();

    // Random traffic, reader never overtakes and moves at most one step per cycle.
    do_reset();
    for (int i = 0; i < 10000; i++) begin
      logic w, c;
      w = ($urandom_range(0, 99) < 60);
      c = ($urandom_range(0, 31) == 0);
      if (rd < m_wcnt && $urandom_range(0, 2) != 0) rd = rd + 1;
      step(w, c);
    end

    @(negedge wclk);
    #1;
    vectors++;
    if (sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
